// File: rtl/pe_r2_sdf.sv
// pe_r2_sdf: radix-2 single-path delay-feedback FFT stage.
//
// Sample n is paired with sample n+DEPTH through a DEPTH-long feedback delay line.
// During phase 1 the stage emits head+in and stores head-in back into the delay line.
// During the next phase 0 it emits those stored diffs multiplied by the external
// twiddle while refilling the line with fresh input. Every output is shifted right
// by `scaling` and then reduced to DW bits.
//
// Build option: define PE_SAT_EN to clamp out-of-range results. Without it they wrap.
// ovf is set in both builds.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      synchronous active-low reset
//   in_valid   input sample valid; the pipeline advances only when it is high
//   in_r/in_i  input sample, DW-bit signed real/imag
//   tw_r/tw_i  twiddle, Q1.(TW_W-2); used on phase-0 advances only
//   scaling    arithmetic right shift 0..3 applied to every output
//   out_valid  output valid
//   out_r/out_i output sample, DW-bit signed real/imag
//   ovf        sticky overflow flag, cleared only by reset
module pe_r2_sdf #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int TW_W  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_r,
  input  logic [DW-1:0]   in_i,
  input  logic [TW_W-1:0] tw_r,
  input  logic [TW_W-1:0] tw_i,
  input  logic [1:0]      scaling,
  output logic            out_valid,
  output logic [DW-1:0]   out_r,
  output logic [DW-1:0]   out_i,
  output logic            ovf
);

  localparam int CW = $clog2(DEPTH) + 1;  // phase is the MSB
  localparam int HW = DW + 1;             // sum/diff width
  localparam int PW = HW + TW_W;          // full product width
  localparam int WW = PW + 1;             // complex product / common working width
  localparam int SH = TW_W - 2;

  localparam logic signed [WW-1:0] MAXV = {{(WW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = ~MAXV;

  logic [CW-1:0] cnt_q;
  logic          primed_q;
  logic [HW-1:0] dl_r [DEPTH];
  logic [HW-1:0] dl_i [DEPTH];

  logic          phase;
  logic          emit;
  logic [HW-1:0] head_r, head_i, in_xr, in_xi;
  logic [HW-1:0] sum_r, sum_i, diff_r, diff_i;
  logic [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic [WW-1:0] mul_r, mul_i;
  logic signed [WW-1:0] mul_sh_r, mul_sh_i, pre_r, pre_i, scl_r, scl_i;
  logic          ovf_now;

  // Reduce a scaled result to DW bits: clamp or keep the low bits.
  function automatic logic [DW-1:0] reduce(input logic signed [WW-1:0] v);
`ifdef PE_SAT_EN
    if (v > MAXV) return MAXV[DW-1:0];
    if (v < MINV) return MINV[DW-1:0];
`endif
    return v[DW-1:0];
  endfunction

  assign phase  = cnt_q[CW-1];
  assign emit   = in_valid & (phase | primed_q);
  assign head_r = dl_r[DEPTH-1];
  assign head_i = dl_i[DEPTH-1];
  assign in_xr  = {in_r[DW-1], in_r};
  assign in_xi  = {in_i[DW-1], in_i};

  assign sum_r  = head_r + in_xr;
  assign sum_i  = head_i + in_xi;
  assign diff_r = head_r - in_xr;
  assign diff_i = head_i - in_xi;

  // Operands are sign-extended to the product width so the low PW bits are exact.
  assign p_rr = {{TW_W{head_r[HW-1]}}, head_r} * {{HW{tw_r[TW_W-1]}}, tw_r};
  assign p_ii = {{TW_W{head_i[HW-1]}}, head_i} * {{HW{tw_i[TW_W-1]}}, tw_i};
  assign p_ri = {{TW_W{head_r[HW-1]}}, head_r} * {{HW{tw_i[TW_W-1]}}, tw_i};
  assign p_ir = {{TW_W{head_i[HW-1]}}, head_i} * {{HW{tw_r[TW_W-1]}}, tw_r};

  assign mul_r = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
  assign mul_i = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};

  always_comb begin
    mul_sh_r = $signed(mul_r) >>> SH;
    mul_sh_i = $signed(mul_i) >>> SH;
    pre_r    = phase ? $signed({{(WW - HW){sum_r[HW-1]}}, sum_r}) : mul_sh_r;
    pre_i    = phase ? $signed({{(WW - HW){sum_i[HW-1]}}, sum_i}) : mul_sh_i;
    scl_r    = pre_r >>> scaling;
    scl_i    = pre_i >>> scaling;
    ovf_now  = (scl_r > MAXV) || (scl_r < MINV) || (scl_i > MAXV) || (scl_i < MINV);
  end

  // Delay line: not reset; stale contents are never emitted because primed gates them.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      dl_r[0] <= phase ? diff_r : in_xr;
      dl_i[0] <= phase ? diff_i : in_xi;
      for (int k = 1; k < DEPTH; k++) begin
        dl_r[k] <= dl_r[k-1];
        dl_i[k] <= dl_i[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= emit;
      if (in_valid) begin
        cnt_q <= cnt_q + CW'(1);
        if (phase) primed_q <= 1'b1;
      end
      if (emit) begin
        out_r <= reduce(scl_r);
        out_i <= reduce(scl_i);
        ovf   <= ovf | ovf_now;
      end
    end
  end

endmodule
